// File: rtl/fpro_bus_arbiter_pkg.sv
// +----------------------------------------------------------------------------+
// | Module   : fpro_arb_pkg                                                    |
// | Brief    : Shared types and constants for the FPro two-master arbiter.     |
// | Revision : 1.0                                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

package fpro_arb_pkg;

    localparam int FP_ADDR_W = 21;
    localparam int FP_DATA_W = 32;
    localparam int LOCK_MAX  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        ACK  = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic                 wr;
        logic                 rd;
        logic                 video_cs;
        logic                 mmio_cs;
        logic [FP_ADDR_W-1:0] addr;
        logic [FP_DATA_W-1:0] wr_data;
    } fpro_cmd_t;

endpackage

`default_nettype wire

// File: rtl/fpro_bus_arbiter_rr_pick2.sv
// +----------------------------------------------------------------------------+
// | Module   : rr_pick2                                                        |
// | Brief    : Combinational two-way round-robin picker with lock override.    |
// | Revision : 1.0                                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module rr_pick2 (
    input  logic [1:0] i_req,
    input  logic       i_last,
    input  logic       i_lock_hold,
    output logic       o_valid,
    output logic       o_pick
);

    always_comb begin
        o_valid = |i_req;
        o_pick  = 1'b0;
        // A held lock only matters while its owner is still asking for the bus.
        if (i_lock_hold && i_req[i_last]) begin
            o_pick = i_last;
        end else if (i_req[0] && i_req[1]) begin
            o_pick = ~i_last;
        end else begin
            o_pick = i_req[1];
        end
    end

endmodule

`default_nettype wire

// File: rtl/fpro_bus_arbiter.sv
// +----------------------------------------------------------------------------+
// | Module   : fpro_bus_arbiter                                                |
// | Brief    : Round-robin two-master arbiter serialising single-word FPro     |
// |            transactions (IDLE -> BUS -> ACK). Define FPRO_ARB_LOCK_EN to    |
// |            enable the bounded bus-lock feature.                            |
// | Revision : 1.0                                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module fpro_bus_arbiter
    import fpro_arb_pkg::*;
#(
    parameter int ADDR_W = FP_ADDR_W,
    parameter int DATA_W = FP_DATA_W
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [1:0]             m_req,
    input  logic [1:0]             m_wr,
    input  logic [1:0]             m_rd,
    input  logic [1:0]             m_video_cs,
    input  logic [1:0]             m_mmio_cs,
    input  logic [1:0][ADDR_W-1:0] m_addr,
    input  logic [1:0][DATA_W-1:0] m_wr_data,
    input  logic [1:0]             m_lock,
    output logic [1:0]             m_ack,
    output logic [DATA_W-1:0]      m_rd_data,
    output logic                   fp_video_cs,
    output logic                   fp_mmio_cs,
    output logic                   fp_wr,
    output logic                   fp_rd,
    output logic [ADDR_W-1:0]      fp_addr,
    output logic [DATA_W-1:0]      fp_wr_data,
    input  logic [DATA_W-1:0]      fp_rd_data,
    output logic [1:0]             grant
);

    arb_state_t        state_q, state_d;
    fpro_cmd_t         cmd_q, cmd_d;
    logic [1:0]        grant_q, grant_d;
    logic              last_q, last_d;
    logic              win_q, win_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;

    logic              pick_valid;
    logic              pick;
    logic              lock_hold;
    logic              bus_phase;

    rr_pick2 u_pick (
        .i_req       (m_req),
        .i_last      (last_q),
        .i_lock_hold (lock_hold),
        .o_valid     (pick_valid),
        .o_pick      (pick)
    );

    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        grant_d   = grant_q;
        last_d    = last_q;
        win_d     = win_q;
        rd_data_d = rd_data_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    win_d            = pick;
                    grant_d          = {pick, ~pick};
                    cmd_d.wr         = m_wr[pick];
                    // A command asking for both directions is treated as a write.
                    cmd_d.rd         = m_rd[pick] & ~m_wr[pick];
                    cmd_d.video_cs   = m_video_cs[pick];
                    cmd_d.mmio_cs    = m_mmio_cs[pick];
                    cmd_d.addr       = FP_ADDR_W'(m_addr[pick]);
                    cmd_d.wr_data    = FP_DATA_W'(m_wr_data[pick]);
                    state_d          = BUS;
                end
            end
            BUS: begin
                if (cmd_q.rd) begin
                    rd_data_d = fp_rd_data;
                end
                state_d = ACK;
            end
            ACK: begin
                last_d  = win_q;
                grant_d = 2'b00;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cmd_q     <= '0;
            grant_q   <= 2'b00;
            last_q    <= 1'b1;
            win_q     <= 1'b0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            win_q     <= win_d;
            rd_data_q <= rd_data_d;
        end
    end

`ifdef FPRO_ARB_LOCK_EN
    logic       lock_hold_q, lock_hold_d;
    logic [2:0] streak_q, streak_d;

    // streak_q counts lock-extended grants after the first; the lock is refused
    // once the owner has held LOCK_MAX grants in a row.
    always_comb begin
        lock_hold_d = lock_hold_q;
        streak_d    = streak_q;
        if (state_q == IDLE) begin
            lock_hold_d = 1'b0;
            if (pick_valid) begin
                streak_d = (lock_hold_q && (pick == last_q)) ? streak_q + 3'd1 : 3'd0;
            end
        end else if (state_q == ACK) begin
            lock_hold_d = m_lock[win_q] && (streak_q != 3'(LOCK_MAX - 1));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lock_hold_q <= 1'b0;
            streak_q    <= 3'd0;
        end else begin
            lock_hold_q <= lock_hold_d;
            streak_q    <= streak_d;
        end
    end

    assign lock_hold = lock_hold_q;
`else
    logic unused_lock;
    assign unused_lock = ^m_lock;
    assign lock_hold   = 1'b0;
`endif

    assign bus_phase   = (state_q == BUS);
    assign fp_wr       = bus_phase & cmd_q.wr;
    assign fp_rd       = bus_phase & cmd_q.rd;
    assign fp_video_cs = bus_phase & cmd_q.video_cs;
    assign fp_mmio_cs  = bus_phase & cmd_q.mmio_cs;
    assign fp_addr     = bus_phase ? ADDR_W'(cmd_q.addr) : '0;
    assign fp_wr_data  = bus_phase ? DATA_W'(cmd_q.wr_data) : '0;
    assign m_ack       = (state_q == ACK) ? {win_q, ~win_q} : 2'b00;
    assign m_rd_data   = rd_data_q;
    assign grant       = grant_q;

endmodule

`default_nettype wire
